wb_traffic_master: RTL and testbench

- Wishbone classic-cycle bus master that generates self-checking traffic for system bring-up.
- Sits directly upstream of the 2xN Wishbone interconnect and drives one of its master ports.
- For each slave window it writes a block of LFSR-derived words, reads them back and compares the data.
- Pass/error status and counters feed LEDs or a debug readout.

---
 rtl/wb_traffic_master.sv | 279 +++++++++++++++++++++++++++
 tb/tb_wb_traffic_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_traffic_master.sv
// wb_traffic_master: Wishbone classic-cycle bring-up traffic generator.
// For each slave window, writes a block of LFSR words, reads them back and
// compares. Pass/error counters and the first failing address are exported.
// Optional build macro WB_TRAFFIC_MASTER_TIMEOUT_EN adds an ACK wait timeout
// (sticky timeout_seen); without it the master waits forever for ACK/ERR.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for enable; bus idle
// WR_SETUP | register write address/data; CYC low this cycle
// WR_WAIT  | write cycle on the bus; waits for ACK/ERR
// RD_SETUP | register read address; CYC low this cycle
// RD_WAIT  | read cycle on the bus; waits for ACK/ERR, compares DAT_R
// PASS_END | bump pass counter, restart or return to IDLE
module wb_traffic_master #(
  parameter int          WB_ADDR_WIDTH   = 32,
  parameter int          WB_DATA_WIDTH   = 32,
  parameter int          NUM_SLAVES      = 4,
  parameter int          WORDS_PER_SLAVE = 16,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_0001,
  parameter int          TIMEOUT_CYCLES  = 255
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                enable,
  input  logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] addr_base,
  output logic [WB_ADDR_WIDTH-1:0]            ADR,
  output logic [WB_DATA_WIDTH-1:0]            DAT_W,
  input  logic [WB_DATA_WIDTH-1:0]            DAT_R,
  output logic [3:0]                          SEL,
  output logic                                CYC,
  output logic                                STB,
  output logic                                WE,
  output logic [2:0]                          CTI,
  output logic [1:0]                          BTE,
  input  logic                                ACK,
  input  logic                                ERR,
  output logic                                busy,
  output logic [15:0]                         pass_cnt,
  output logic [15:0]                         err_cnt,
  output logic [WB_ADDR_WIDTH-1:0]            first_err_addr,
  output logic                                timeout_seen
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int IW = (WORDS_PER_SLAVE > 1) ? $clog2(WORDS_PER_SLAVE) : 1;
  localparam logic [WB_DATA_WIDTH-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SETUP = 3'd1,
    WR_WAIT  = 3'd2,
    RD_SETUP = 3'd3,
    RD_WAIT  = 3'd4,
    PASS_END = 3'd5
  } state_t;

  state_t                     state_q, state_d;
  logic [SW-1:0]              s_q, s_d;
  logic [IW-1:0]              i_q, i_d;
  logic [WB_DATA_WIDTH-1:0]   lfsr_q, lfsr_d, snap_q, snap_d;
  logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0]   dat_w_q, dat_w_d;
  logic                       we_q, we_d, cyc_q, cyc_d, stb_q, stb_d;
  logic                       busy_q, busy_d;
  logic [15:0]                pass_cnt_q, pass_cnt_d, err_cnt_q, err_cnt_d;
  logic [WB_ADDR_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;

  logic [WB_ADDR_WIDTH-1:0]   base_sel, xfer_adr;
  logic [WB_DATA_WIDTH-1:0]   lfsr_next;
  logic                       in_wait, tmo, rsp_done, rsp_err, count_err;
  logic                       last_i, last_s;

  // Select the base address of the current slave window.
  always_comb begin
    base_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (s_q == SW'(k)) base_sel = addr_base[k*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
    end
  end

  assign xfer_adr  = base_sel + WB_ADDR_WIDTH'({i_q, 2'b00});
  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign in_wait   = (state_q == WR_WAIT) || (state_q == RD_WAIT);
  assign last_i    = (i_q == IW'(WORDS_PER_SLAVE - 1));
  assign last_s    = (s_q == SW'(NUM_SLAVES - 1));

`ifdef WB_TRAFFIC_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_seen_q, timeout_seen_d;

  // Abort on the TIMEOUT_CYCLES-th wait cycle that sees neither ACK nor ERR.
  assign tmo = in_wait && !(ACK || ERR) && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Wait counter: cleared in SETUP, counts every WAIT cycle.
  always_comb begin
    wait_cnt_d     = wait_cnt_q;
    timeout_seen_d = timeout_seen_q | tmo;
    if ((state_q == WR_SETUP) || (state_q == RD_SETUP)) wait_cnt_d = '0;
    else if (in_wait) wait_cnt_d = wait_cnt_q + TW'(1);
  end

  // Timeout counter and sticky flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q     <= '0;
      timeout_seen_q <= 1'b0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      timeout_seen_q <= timeout_seen_d;
    end
  end

  assign timeout_seen = timeout_seen_q;
`else
  assign tmo          = 1'b0;
  assign timeout_seen = 1'b0;
`endif

  // A timeout behaves exactly like an ERR response.
  assign rsp_done = ACK || ERR || tmo;
  assign rsp_err  = ERR || tmo;

  // Next-state, bus outputs, LFSR sequencing and error detection.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    i_d      = i_q;
    lfsr_d   = lfsr_q;
    snap_d   = snap_q;
    adr_d    = adr_q;
    dat_w_d  = dat_w_q;
    we_d     = we_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    busy_d   = busy_q;
    pass_cnt_d = pass_cnt_q;
    count_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WR_SETUP;
          s_d     = '0;
          i_d     = '0;
          busy_d  = 1'b1;
          snap_d  = lfsr_q;
        end
      end
      WR_SETUP: begin
        adr_d   = xfer_adr;
        dat_w_d = lfsr_q;
        we_d    = 1'b1;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (rsp_done) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          we_d      = 1'b0;
          count_err = rsp_err;
          lfsr_d    = lfsr_next;
          if (last_i) begin
            // Rewind so the read phase regenerates the written words.
            i_d     = '0;
            lfsr_d  = snap_q;
            state_d = RD_SETUP;
          end else begin
            i_d     = i_q + IW'(1);
            state_d = WR_SETUP;
          end
        end
      end
      RD_SETUP: begin
        adr_d   = xfer_adr;
        we_d    = 1'b0;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (rsp_done) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          // ACK together with ERR counts once, without a data compare.
          count_err = rsp_err || (DAT_R != lfsr_q);
          lfsr_d    = lfsr_next;
          if (last_i) begin
            if (last_s) begin
              state_d = PASS_END;
            end else begin
              s_d     = s_q + SW'(1);
              i_d     = '0;
              snap_d  = lfsr_next;
              state_d = WR_SETUP;
            end
          end else begin
            i_d     = i_q + IW'(1);
            state_d = RD_SETUP;
          end
        end
      end
      PASS_END: begin
        pass_cnt_d = pass_cnt_q + 16'd1;
        if (enable) begin
          snap_d  = lfsr_q;
          s_d     = '0;
          i_d     = '0;
          state_d = WR_SETUP;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating error counter; first failing address latches once.
  always_comb begin
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    if (count_err) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == 16'd0) first_err_addr_d = adr_q;
    end
  end

  // State, sequencing and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= IDLE;
      s_q              <= '0;
      i_q              <= '0;
      lfsr_q           <= LFSR_SEED;
      snap_q           <= LFSR_SEED;
      adr_q            <= '0;
      dat_w_q          <= '0;
      we_q             <= 1'b0;
      cyc_q            <= 1'b0;
      stb_q            <= 1'b0;
      busy_q           <= 1'b0;
      pass_cnt_q       <= '0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
    end else begin
      state_q          <= state_d;
      s_q              <= s_d;
      i_q              <= i_d;
      lfsr_q           <= lfsr_d;
      snap_q           <= snap_d;
      adr_q            <= adr_d;
      dat_w_q          <= dat_w_d;
      we_q             <= we_d;
      cyc_q            <= cyc_d;
      stb_q            <= stb_d;
      busy_q           <= busy_d;
      pass_cnt_q       <= pass_cnt_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
    end
  end

  assign ADR            = adr_q;
  assign DAT_W          = dat_w_q;
  assign WE             = we_q;
  assign CYC            = cyc_q;
  assign STB            = stb_q;
  assign SEL            = 4'hF;
  assign CTI            = 3'b000;
  assign BTE            = 2'b00;
  assign busy           = busy_q;
  assign pass_cnt       = pass_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_wb_traffic_master.sv
// Bench for wb_traffic_master: zero-wait SRAM slaves with fault knobs, an
// expected-transfer queue filled per pass and a negedge bus monitor.
module tb_wb_traffic_master;

  localparam int          AW       = 32;
  localparam int          NS       = 4;
  localparam int          WPS      = 4;
  localparam logic [31:0] SEED     = 32'hACE1_0001;
  localparam int          PASS_CYC = 4*NS*WPS + 1;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } xfer_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            enable = 1'b0;
  logic [NS*AW-1:0] addr_base;
  logic [AW-1:0]   ADR;
  logic [31:0]     DAT_W, DAT_R;
  logic [3:0]      SEL;
  logic            CYC, STB, WE, ACK, ERR;
  logic [2:0]      CTI;
  logic [1:0]      BTE;
  logic            busy, timeout_seen;
  logic [15:0]     pass_cnt, err_cnt;
  logic [AW-1:0]   first_err_addr;

  logic            clr_mem = 1'b0;
  logic            flip_208 = 1'b0;
  logic            err_wr_100 = 1'b0;
  logic            hang_s3 = 1'b0;
  logic [31:0]     mem [0:255];
  logic            slv_ack, slv_err;

  xfer_t           exp_q[$];
  logic [31:0]     m_lfsr;
  int              n_vec = 0;
  int              n_bad = 0;

  logic            cyc_prev = 1'b0;
  int              xfer_idx = 0;
  logic [31:0]     f_adr, f_dat, s_dat;
  logic            f_we;
  logic [15:0]     cap_err_rd100 = 16'hFFFF;

  assign addr_base = {32'h300, 32'h200, 32'h100, 32'h000};

  always #5 clk = ~clk;

  wb_traffic_master #(
    .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(32), .NUM_SLAVES(NS),
    .WORDS_PER_SLAVE(WPS), .LFSR_SEED(SEED), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .addr_base(addr_base),
    .ADR(ADR), .DAT_W(DAT_W), .DAT_R(DAT_R), .SEL(SEL), .CYC(CYC),
    .STB(STB), .WE(WE), .CTI(CTI), .BTE(BTE), .ACK(ACK), .ERR(ERR),
    .busy(busy), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .timeout_seen(timeout_seen)
  );

  // Zero-wait slave responder with fault injection knobs.
  always_comb begin
    slv_ack = CYC & STB;
    slv_err = 1'b0;
    if (hang_s3 && ADR[9:8] == 2'd3) slv_ack = 1'b0;
    if (err_wr_100 && WE && ADR == 32'h100) begin
      slv_ack = 1'b0;
      slv_err = CYC & STB;
    end
    DAT_R = mem[ADR[9:2]];
    if (flip_208 && ADR == 32'h208) DAT_R[0] = ~DAT_R[0];
  end
  assign ACK = slv_ack;
  assign ERR = slv_err;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
    end else if (CYC && STB && WE && slv_ack) begin
      mem[ADR[9:2]] <= DAT_W;
    end
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Expected bus transfers for one full pass.
  task automatic plan_pass();
    logic [31:0] snap;
    xfer_t x;
    for (int s = 0; s < NS; s++) begin
      snap = m_lfsr;
      for (int i = 0; i < WPS; i++) begin
        x.adr = (32'(s) << 8) + 32'(4*i); x.we = 1'b1; x.dat = m_lfsr;
        exp_q.push_back(x);
        m_lfsr = lfsr_step(m_lfsr);
      end
      m_lfsr = snap;
      for (int i = 0; i < WPS; i++) begin
        x.adr = (32'(s) << 8) + 32'(4*i); x.we = 1'b0; x.dat = 32'h0;
        exp_q.push_back(x);
        m_lfsr = lfsr_step(m_lfsr);
      end
    end
  endtask

  // Monitor: every new bus cycle (CYC rising) is checked against the queue.
  always @(negedge clk) begin
    xfer_t e;
    if (!rstn) begin
      cyc_prev = 1'b0;
      xfer_idx = 0;
      cap_err_rd100 = 16'hFFFF;
    end else begin
      if (CYC && !cyc_prev) begin
        if (xfer_idx == 0) begin f_adr = ADR; f_dat = DAT_W; f_we = WE; end
        if (xfer_idx == 1) s_dat = DAT_W;
        if (!WE && ADR == 32'h100) cap_err_rd100 = err_cnt;
        xfer_idx++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL xfer_unexpected: adr=0x%08h we=%0d dat=0x%08h, none expected", ADR, WE, DAT_W);
        end else begin
          e = exp_q.pop_front();
          if (ADR !== e.adr || WE !== e.we || STB !== 1'b1 || (e.we && DAT_W !== e.dat)) begin
            n_bad++;
            $display("FAIL xfer: got adr=0x%08h we=%0d stb=%0d dat=0x%08h expected adr=0x%08h we=%0d dat=0x%08h",
                     ADR, WE, STB, DAT_W, e.adr, e.we, e.dat);
          end
        end
      end
      cyc_prev = CYC;
    end
  end

  task automatic do_reset();
    rstn = 1'b0; enable = 1'b0; clr_mem = 1'b1;
    exp_q.delete();
    m_lfsr = SEED;
    repeat (2) @(posedge clk);
    #1; clr_mem = 1'b0; rstn = 1'b1;
  endtask

  task automatic run_pass(input int exp_cyc, input string nm);
    int cnt;
    @(posedge clk); #1; enable = 1'b1; plan_pass();
    @(posedge clk); #1; enable = 1'b0;
    cnt = 0;
    while (busy && cnt < 20000) begin @(posedge clk); #1; cnt++; end
    chk({nm, "_cycles"}, 32'(cnt), 32'(exp_cyc));
    chk({nm, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int cnt;
    bit found;

    // Scenario 1: clean pass.
    do_reset();
    chk("rst_adr", ADR, 32'h0);
    chk("rst_datw", DAT_W, 32'h0);
    chk("rst_cyc_stb_we", {29'h0, CYC, STB, WE}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_pass_cnt", {16'h0, pass_cnt}, 32'h0);
    chk("rst_err_cnt", {16'h0, err_cnt}, 32'h0);
    chk("rst_first_err", first_err_addr, 32'h0);
    chk("rst_timeout", {31'h0, timeout_seen}, 32'h0);
    chk("sel_cti_bte", {23'h0, SEL, CTI, BTE}, {23'h0, 4'hF, 3'b000, 2'b00});
    run_pass(PASS_CYC, "clean");
    chk("clean_first_adr", f_adr, 32'h0);
    chk("clean_first_dat", f_dat, 32'hACE1_0001);
    chk("clean_first_we", {31'h0, f_we}, 32'h1);
    chk("clean_second_dat", s_dat, 32'hD650_8003);
    chk("clean_pass_cnt", {16'h0, pass_cnt}, 32'd1);
    chk("clean_err_cnt", {16'h0, err_cnt}, 32'd0);
    chk("clean_busy", {31'h0, busy}, 32'h0);
    chk("clean_timeout", {31'h0, timeout_seen}, 32'h0);

    // Scenario 2: read data corruption at 0x208.
    do_reset();
    flip_208 = 1'b1;
    run_pass(PASS_CYC, "flip");
    flip_208 = 1'b0;
    chk("flip_err_cnt", {16'h0, err_cnt}, 32'd1);
    chk("flip_first_err", first_err_addr, 32'h208);
    chk("flip_pass_cnt", {16'h0, pass_cnt}, 32'd1);

    // Scenario 3: asynchronous reset in the middle of a write.
    @(posedge clk); #1; enable = 1'b1; plan_pass();
    @(posedge clk); #1; enable = 1'b0;
    found = 1'b0;
    cnt = 0;
    while (!found && cnt < 200) begin
      @(posedge clk); #1; cnt++;
      if (CYC && WE && ADR == 32'h008) found = 1'b1;
    end
    chk("arst_reached_wr_wait", {31'h0, found}, 32'h1);
    #2; rstn = 1'b0;
    #1;
    chk("arst_cyc_stb_we", {29'h0, CYC, STB, WE}, 32'h0);
    chk("arst_pass_cnt", {16'h0, pass_cnt}, 32'd0);
    chk("arst_err_cnt", {16'h0, err_cnt}, 32'd0);
    chk("arst_first_err", first_err_addr, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    do_reset();
    run_pass(PASS_CYC, "after_rst");
    chk("after_rst_first_dat", f_dat, 32'hACE1_0001);
    chk("after_rst_err_cnt", {16'h0, err_cnt}, 32'd0);
    chk("after_rst_pass_cnt", {16'h0, pass_cnt}, 32'd1);

    // Scenario 4: ERR on the write to 0x100, then the read mismatches.
    do_reset();
    err_wr_100 = 1'b1;
    run_pass(PASS_CYC, "werr");
    err_wr_100 = 1'b0;
    chk("werr_err_at_read", {16'h0, cap_err_rd100}, 32'd1);
    chk("werr_err_cnt", {16'h0, err_cnt}, 32'd2);
    chk("werr_first_err", first_err_addr, 32'h100);
    chk("werr_pass_cnt", {16'h0, pass_cnt}, 32'd1);

    // Scenario 5: enable held, dropped part-way through pass 2.
    do_reset();
    @(posedge clk); #1; enable = 1'b1; plan_pass(); plan_pass();
    @(posedge clk); #1;
    cnt = 0;
    while (busy && cnt < 20000) begin
      @(posedge clk); #1; cnt++;
      if (cnt == PASS_CYC + 20) enable = 1'b0;
    end
    chk("run2_cycles", 32'(cnt), 32'(2*PASS_CYC));
    chk("run2_pass_cnt", {16'h0, pass_cnt}, 32'd2);
    chk("run2_busy", {31'h0, busy}, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    chk("run2_idle_cyc", {31'h0, CYC}, 32'h0);
    chk("run2_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef WB_TRAFFIC_MASTER_TIMEOUT_EN
    // Scenario 6: slave 3 never answers; every transfer times out.
    do_reset();
    hang_s3 = 1'b1;
    run_pass(PASS_CYC + 8*254, "tmo");
    hang_s3 = 1'b0;
    chk("tmo_err_cnt", {16'h0, err_cnt}, 32'd8);
    chk("tmo_first_err", first_err_addr, 32'h300);
    chk("tmo_flag", {31'h0, timeout_seen}, 32'h1);
    chk("tmo_pass_cnt", {16'h0, pass_cnt}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", n_vec, n_bad);
    $fatal(1);
  end

endmodule
